// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, flush, optional 2-entry skid buffer.
// Optional performance counters (bubble_cnt, flush_cnt) are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_FULL  = 2'd1;
            localparam logic [1:0] ST_SKID  = 2'd2;

            logic [1:0]        r_state;
            logic [1:0]        w_state_next;
            logic [CTRL_W-1:0] r_m_ctrl;
            logic [DATA_W-1:0] r_m_data;
            logic [CTRL_W-1:0] r_s_ctrl;
            logic [DATA_W-1:0] r_s_data;
            logic              r_in_ready;
            logic              w_valid;
            logic              w_accept;
            logic              w_emit;

            assign w_valid  = (r_state != ST_EMPTY);
            assign w_accept = in_valid & r_in_ready;
            assign w_emit   = w_valid & out_ready;

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
                    ST_FULL: begin
                        if (w_accept && !w_emit)      w_state_next = ST_SKID;
                        else if (w_emit && !w_accept) w_state_next = ST_EMPTY;
                    end
                    ST_SKID:  if (w_emit) w_state_next = ST_FULL;
                    default:  w_state_next = ST_EMPTY;
                endcase
            end

            // in_ready is registered from the next state so out_ready never reaches it combinationally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state    <= ST_EMPTY;
                    r_m_ctrl   <= '0;
                    r_m_data   <= '0;
                    r_s_ctrl   <= '0;
                    r_s_data   <= '0;
                    r_in_ready <= 1'b1;
                end else if (flush) begin
                    r_state    <= ST_EMPTY;
                    r_m_ctrl   <= '0;
                    r_s_ctrl   <= '0;
                    r_s_data   <= '0;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_next;
                    r_in_ready <= (w_state_next != ST_SKID);
                    if (w_accept && (r_state == ST_EMPTY || w_emit)) begin
                        r_m_ctrl <= in_ctrl;
                        r_m_data <= in_data;
                    end
                    if (w_accept && r_state == ST_FULL && !w_emit) begin
                        r_s_ctrl <= in_ctrl;
                        r_s_data <= in_data;
                    end
                    if (r_state == ST_SKID && w_emit) begin
                        r_m_ctrl <= r_s_ctrl;
                        r_m_data <= r_s_data;
                    end
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = w_valid;
            assign out_ctrl  = w_valid ? r_m_ctrl : '0;
            assign out_data  = r_m_data;
        end else begin : g_single
            logic              r_valid;
            logic [CTRL_W-1:0] r_ctrl;
            logic [DATA_W-1:0] r_data;
            logic              w_ready;

            assign w_ready = ~r_valid | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end else if (in_valid && w_ready) begin
                    r_valid <= 1'b1;
                    r_ctrl  <= in_ctrl;
                    r_data  <= in_data;
                end else if (r_valid && out_ready) begin
                    r_valid <= 1'b0;
                end
            end

            assign in_ready  = w_ready;
            assign out_valid = r_valid;
            assign out_ctrl  = r_valid ? r_ctrl : '0;
            assign out_data  = r_data;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!out_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (flush)      r_flush_cnt  <= r_flush_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one SKID=1 and one SKID=0 stage with shared stimulus and checks both
// every cycle against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_data;
    logic [1:0]  ir, ov;
    logic [1:0]  oc [2];
    logic [31:0] od [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bc [2];
    logic [31:0] fc [2];
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0])
`ifdef PIPE_STAGE_PERF_EN
        , .bubble_cnt(bc[0]), .flush_cnt(fc[0])
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1])
`ifdef PIPE_STAGE_PERF_EN
        , .bubble_cnt(bc[1]), .flush_cnt(fc[1])
`endif
    );

    // Reference model: entries held per instance (capacity 2 with skid, 1 without).
    int          cnt [2];
    logic [33:0] ent [2][2];
    logic [31:0] last_data [2];
    logic [31:0] pb [2];
    logic [31:0] pf [2];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          verbose = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] c, input logic [31:0] d,
                       input logic ordy, input logic fl, input logic rs, input string tag);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit          ev  = (cnt[k] > 0);
            logic [1:0]  ec  = ev ? ent[k][0][33:32] : 2'b00;
            logic [31:0] ed  = ev ? ent[k][0][31:0] : last_data[k];
            bit          eir = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || ordy);
            bit          emit, acc;
            check($sformatf("%s.%0d.out_valid", tag, k), 64'(ov[k]), 64'(ev));
            check($sformatf("%s.%0d.out_ctrl", tag, k), 64'(oc[k]), 64'(ec));
            check($sformatf("%s.%0d.out_data", tag, k), 64'(od[k]), 64'(ed));
            check($sformatf("%s.%0d.in_ready", tag, k), 64'(ir[k]), 64'(eir));
`ifdef PIPE_STAGE_PERF_EN
            check($sformatf("%s.%0d.bubble_cnt", tag, k), 64'(bc[k]), 64'(pb[k]));
            check($sformatf("%s.%0d.flush_cnt", tag, k), 64'(fc[k]), 64'(pf[k]));
`endif
            if (rs) begin
                pb[k] = 0;
                pf[k] = 0;
            end else begin
                if (!ev) pb[k] = pb[k] + 32'd1;
                if (fl)  pf[k] = pf[k] + 32'd1;
            end
            if (rs) begin
                cnt[k] = 0;
                last_data[k] = '0;
            end else if (fl) begin
                if (ev) last_data[k] = ed;
                cnt[k] = 0;
            end else begin
                emit = ev && ordy;
                acc  = v && eir;
                if (emit) begin
                    last_data[k] = ed;
                    ent[k][0] = ent[k][1];
                    cnt[k]--;
                    if (verbose)
                        $display("%s inst%0d emit ctrl=%0h data=%08h", tag, k, ec, ed);
                end
                if (acc) begin
                    ent[k][cnt[k]] = {c, d};
                    cnt[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; last_data[k] = '0; pb[k] = '0; pf[k] = '0;
            ent[k][0] = '0; ent[k][1] = '0;
        end
        // First reset edge is unchecked: outputs are undefined before it.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11;
        in_data = 32'hDEADBEEF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 2'b11, 32'hDEADBEEF, 1, 0, 1, "reset");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "post_reset");

        for (int i = 1; i <= 4; i++) cyc(1, 2'b01, i, 1, 0, 0, "stream");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "stream_tail");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "stream_tail");

        cyc(1, 2'b10, 32'h10, 1, 0, 0, "skid_a");
        cyc(1, 2'b10, 32'h20, 0, 0, 0, "skid_b");
        cyc(0, 2'b00, 32'h0, 0, 0, 0, "skid_hold");
        cyc(0, 2'b00, 32'h0, 0, 0, 0, "skid_hold");
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 32'h0, 1, 0, 0, "skid_drain");

        cyc(1, 2'b01, 32'h30, 1, 0, 0, "flush_fill");
        cyc(1, 2'b01, 32'h40, 0, 0, 0, "flush_fill");
        cyc(0, 2'b00, 32'h0, 0, 0, 0, "flush_skid");
        cyc(1, 2'b11, 32'h99, 0, 1, 0, "flush");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "post_flush");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "post_flush");

        cyc(1, 2'b01, 32'h55, 0, 0, 0, "noskid_load");
        for (int i = 0; i < 6; i++) cyc(1, 2'b01, 32'h55, logic'(i % 2), 0, 0, "noskid_toggle");

        cyc(0, 2'b00, 32'h0, 1, 0, 1, "perf_reset");
        for (int i = 0; i < 5; i++) cyc(0, 2'b00, 32'h0, 1, 0, 0, "perf_idle");
        cyc(0, 2'b00, 32'h0, 1, 1, 0, "perf_flush");
        cyc(0, 2'b00, 32'h0, 1, 0, 0, "perf_gap");
        cyc(0, 2'b00, 32'h0, 1, 1, 0, "perf_flush");
`ifdef PIPE_STAGE_PERF_EN
        check("perf_flush_cnt_eq2", 64'(fc[0]), 64'd2);
        check("perf_bubble_cnt_ge5", 64'(bc[0] >= 32'd5), 64'd1);
`endif

        verbose = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 29) == 0),
                logic'($urandom_range(0, 99) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
